// File: rtl/fir3_block_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : fir3_block_sequencer
// Description : Serial-to-parallel front end for a 3-phase block FIR filter.
//               Packs three input samples into a block, issues it to the
//               filter with a pipeline-advance strobe, tracks in-flight blocks
//               with a tag shift register, buffers results in a FIFO and
//               re-serialises them. A flush pads a partial block and drains
//               the filter pipeline with bubble advances.
//               Optional statistics port blk_cnt: define FIR3_SEQ_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module fir3_block_sequencer #(
    parameter int DIN_W    = 16,
    parameter int DOUT_W   = 64,
    parameter int FILT_LAT = 3,
    parameter int DEPTH    = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [DIN_W-1:0] s_data,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic                    flush,
    output logic signed [DIN_W-1:0] f_din1,
    output logic signed [DIN_W-1:0] f_din2,
    output logic signed [DIN_W-1:0] f_din3,
    output logic                    f_en,
    input  logic [DOUT_W-1:0]       f_dout1,
    input  logic [DOUT_W-1:0]       f_dout2,
    input  logic [DOUT_W-1:0]       f_dout3,
    output logic [DOUT_W-1:0]       m_data,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic                    flush_done
`ifdef FIR3_SEQ_STATS_EN
    ,
    output logic [15:0]             blk_cnt
`endif
);

    localparam int c_PTR_W   = $clog2(DEPTH);
    localparam int c_CNT_W   = $clog2(DEPTH + 1);
    localparam int c_ENTRY_W = 3 * DOUT_W;
    localparam logic [c_CNT_W-1:0] c_DEPTH_CNT = c_CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        c_ST_RUN   = 2'd0,
        c_ST_PAD   = 2'd1,
        c_ST_DRAIN = 2'd2
    } state_t;

    state_t                    r_state_q, w_state_d;
    logic [1:0]                r_phase_q, w_phase_d;
    logic signed [DIN_W-1:0]   r_slot_q [3];
    logic signed [DIN_W-1:0]   w_slot_d [3];
    logic                      r_full_q, w_full_d;
    logic [FILT_LAT-1:0]       r_tag_q, w_tag_d;
    logic [c_CNT_W-1:0]        r_res_q, w_res_d;
    logic [c_PTR_W:0]          r_wr_ptr_q, w_wr_ptr_d;
    logic [c_PTR_W:0]          r_rd_ptr_q, w_rd_ptr_d;
    logic [1:0]                r_word_q, w_word_d;
    logic                      r_wr_pend_q, w_wr_pend_d;
    logic                      r_alive_q;
    logic [c_ENTRY_W-1:0]      r_mem_q [DEPTH];

    logic                      w_accept;
    logic                      w_room;
    logic                      w_data_issue;
    logic                      w_bubble;
    logic                      w_drain_done;
    logic                      w_pop_word;
    logic                      w_pop_last;
    logic [c_ENTRY_W-1:0]      w_head;

    // Issue arbitration, filter-side outputs and the serial output mux.
    always_comb begin
        s_ready      = r_alive_q && (r_state_q == c_ST_RUN) && !r_full_q;
        w_accept     = s_valid && s_ready;
        w_room       = (r_res_q < c_DEPTH_CNT);
        w_data_issue = 1'b0;
        w_bubble     = 1'b0;
        w_drain_done = 1'b0;
        case (r_state_q)
            c_ST_RUN:   w_data_issue = r_full_q && w_room;
            c_ST_PAD:   w_data_issue = w_room;
            c_ST_DRAIN: begin
                // A block completed together with the flush still goes out as data.
                w_data_issue = r_full_q && w_room;
                w_bubble     = !w_data_issue && ((r_tag_q != '0) || r_full_q);
                w_drain_done = (r_tag_q == '0) && !r_full_q;
            end
            default: ;
        endcase
        f_en       = w_data_issue || w_bubble;
        f_din1     = w_data_issue ? r_slot_q[0] : '0;
        f_din2     = w_data_issue ? r_slot_q[1] : '0;
        f_din3     = w_data_issue ? r_slot_q[2] : '0;
        flush_done = w_drain_done;

        m_valid    = (r_wr_ptr_q != r_rd_ptr_q);
        w_head     = r_mem_q[r_rd_ptr_q[c_PTR_W-1:0]];
        w_pop_word = m_valid && m_ready;
        w_pop_last = w_pop_word && (r_word_q == 2'd2);
        m_data     = '0;
        if (m_valid) begin
            case (r_word_q)
                2'd0:    m_data = w_head[DOUT_W-1:0];
                2'd1:    m_data = w_head[2*DOUT_W-1:DOUT_W];
                default: m_data = w_head[3*DOUT_W-1:2*DOUT_W];
            endcase
        end
    end

    // Next-state computation for the FSM, block register, tags, counter and FIFO.
    always_comb begin
        w_state_d   = r_state_q;
        w_phase_d   = r_phase_q;
        w_slot_d    = r_slot_q;
        w_full_d    = r_full_q;
        w_tag_d     = r_tag_q;
        w_res_d     = r_res_q;
        w_rd_ptr_d  = r_rd_ptr_q;
        w_wr_ptr_d  = r_wr_ptr_q;
        w_word_d    = r_word_q;
        w_wr_pend_d = f_en && r_tag_q[FILT_LAT-1];

        if (w_accept) begin
            w_slot_d[r_phase_q] = s_data;
            // Clearing the later slots on a new block makes padding free.
            if (r_phase_q == 2'd0) begin
                w_slot_d[1] = '0;
                w_slot_d[2] = '0;
            end
            if (r_phase_q == 2'd2) begin
                w_full_d  = 1'b1;
                w_phase_d = 2'd0;
            end else begin
                w_phase_d = r_phase_q + 2'd1;
            end
        end

        if (w_data_issue) begin
            w_full_d  = 1'b0;
            w_phase_d = 2'd0;
        end

        if (f_en) begin
            w_tag_d    = r_tag_q << 1;
            w_tag_d[0] = w_data_issue;
        end

        if (w_data_issue && !w_pop_last) begin
            w_res_d = r_res_q + c_CNT_W'(1);
        end else if (!w_data_issue && w_pop_last) begin
            w_res_d = r_res_q - c_CNT_W'(1);
        end

        if (r_wr_pend_q) begin
            w_wr_ptr_d = r_wr_ptr_q + (c_PTR_W + 1)'(1);
        end
        if (w_pop_word) begin
            w_word_d = (r_word_q == 2'd2) ? 2'd0 : r_word_q + 2'd1;
        end
        if (w_pop_last) begin
            w_rd_ptr_d = r_rd_ptr_q + (c_PTR_W + 1)'(1);
        end

        case (r_state_q)
            c_ST_RUN: begin
                if (flush) begin
                    w_state_d = (w_phase_d != 2'd0) ? c_ST_PAD : c_ST_DRAIN;
                end
            end
            c_ST_PAD: begin
                if (w_data_issue) begin
                    w_state_d = c_ST_DRAIN;
                end
            end
            c_ST_DRAIN: begin
                if (w_drain_done) begin
                    w_state_d = c_ST_RUN;
                end
            end
            default: w_state_d = c_ST_RUN;
        endcase
    end

    // Control and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state_q   <= c_ST_RUN;
            r_phase_q   <= 2'd0;
            for (int i = 0; i < 3; i++) begin
                r_slot_q[i] <= '0;
            end
            r_full_q    <= 1'b0;
            r_tag_q     <= '0;
            r_res_q     <= '0;
            r_wr_ptr_q  <= '0;
            r_rd_ptr_q  <= '0;
            r_word_q    <= 2'd0;
            r_wr_pend_q <= 1'b0;
            r_alive_q   <= 1'b0;
        end else begin
            r_state_q   <= w_state_d;
            r_phase_q   <= w_phase_d;
            r_slot_q    <= w_slot_d;
            r_full_q    <= w_full_d;
            r_tag_q     <= w_tag_d;
            r_res_q     <= w_res_d;
            r_wr_ptr_q  <= w_wr_ptr_d;
            r_rd_ptr_q  <= w_rd_ptr_d;
            r_word_q    <= w_word_d;
            r_wr_pend_q <= w_wr_pend_d;
            r_alive_q   <= 1'b1;
        end
    end

    // Result storage; contents need no reset because the pointers gate them.
    always_ff @(posedge clk) begin
        if (r_wr_pend_q) begin
            r_mem_q[r_wr_ptr_q[c_PTR_W-1:0]] <= {f_dout3, f_dout2, f_dout1};
        end
    end

`ifdef FIR3_SEQ_STATS_EN
    logic [15:0] r_blk_cnt_q, w_blk_cnt_d;

    // Free-running count of data issues, wrapping at 16 bits.
    always_comb begin
        w_blk_cnt_d = r_blk_cnt_q;
        if (w_data_issue) begin
            w_blk_cnt_d = r_blk_cnt_q + 16'd1;
        end
    end

    // Statistics register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_blk_cnt_q <= 16'd0;
        end else begin
            r_blk_cnt_q <= w_blk_cnt_d;
        end
    end

    assign blk_cnt = r_blk_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fir3_block_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fir3_block_sequencer
// Description : Directed self-checking bench for fir3_block_sequencer with a
//               behavioural filter whose word k result is sample*1000 + k.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fir3_block_sequencer;

    localparam int c_LAT = 3;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic signed [15:0] s_data = '0;
    logic               s_valid = 1'b0;
    logic               s_ready;
    logic               flush = 1'b0;
    logic signed [15:0] f_din1, f_din2, f_din3;
    logic               f_en;
    logic [63:0]        f_dout1, f_dout2, f_dout3;
    logic [63:0]        m_data;
    logic               m_valid;
    logic               m_ready = 1'b0;
    logic               flush_done;
`ifdef FIR3_SEQ_STATS_EN
    logic [15:0]        blk_cnt;
`endif

    int                 n_chk  = 0;
    int                 n_pass = 0;
    int                 fd_cnt = 0;
    logic [47:0]        iss_q[$];
    logic [63:0]        out_q[$];
    logic [47:0]        pipe [0:c_LAT];
    logic [47:0]        w_last;

    always #5 clk = ~clk;

    fir3_block_sequencer #(
        .DIN_W(16), .DOUT_W(64), .FILT_LAT(c_LAT), .DEPTH(4)
    ) u_dut (
        .clk(clk), .rst(rst),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .flush(flush),
        .f_din1(f_din1), .f_din2(f_din2), .f_din3(f_din3), .f_en(f_en),
        .f_dout1(f_dout1), .f_dout2(f_dout2), .f_dout3(f_dout3),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .flush_done(flush_done)
`ifdef FIR3_SEQ_STATS_EN
        , .blk_cnt(blk_cnt)
`endif
    );

    function automatic logic [63:0] model(input logic [15:0] x, input int k);
        logic signed [63:0] sx;
        sx = {{48{x[15]}}, x};
        return sx * 64'sd1000 + 64'(k);
    endfunction

    // Behavioural filter: one stage per advance, result after FILT_LAT more.
    always @(posedge clk) begin
        if (f_en) begin
            pipe[0] <= {f_din1, f_din2, f_din3};
            for (int i = 1; i <= c_LAT; i++) pipe[i] <= pipe[i-1];
        end
    end
    assign w_last  = pipe[c_LAT];
    assign f_dout1 = model(w_last[47:32], 1);
    assign f_dout2 = model(w_last[31:16], 2);
    assign f_dout3 = model(w_last[15:0], 3);

    // Monitor: filter issues, output transfers and drain completions.
    always @(negedge clk) begin
        if (f_en) iss_q.push_back({f_din1, f_din2, f_din3});
        if (m_valid && m_ready) out_q.push_back(m_data);
        if (flush_done) fd_cnt = fd_cnt + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    // All stimulus tasks start and end 1 time unit after a rising edge.
    task automatic send(input logic [15:0] v);
        bit ok;
        ok = 1'b0;
        s_valid = 1'b1;
        s_data  = v;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (s_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("accept_timeout", 64'(s_ready), 64'd1);
        @(posedge clk); #1;
        s_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic flush_pulse();
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
    endtask

    task automatic clear_logs();
        iss_q.delete();
        out_q.delete();
        fd_cnt = 0;
    endtask

    initial begin
        logic [47:0] exp_blk;
        logic [63:0] hold0;
        int          rdy_hi;

        // ---- reset state ----
        @(posedge clk); #1;
        idle(2);
        @(negedge clk);
        chk("rst_s_ready", 64'(s_ready), 64'd0);
        chk("rst_f_en", 64'(f_en), 64'd0);
        chk("rst_m_valid", 64'(m_valid), 64'd0);
        chk("rst_flush_done", 64'(flush_done), 64'd0);
        chk("rst_f_din", 64'({f_din1, f_din2, f_din3}), 64'd0);
        chk("rst_m_data", m_data, 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("ready_before_edge", 64'(s_ready), 64'd0);
        @(posedge clk); #1;
        chk("ready_after_edge", 64'(s_ready), 64'd1);

        // ---- single block, then three more to push it out ----
        m_ready = 1'b1;
        send(16'd1); send(16'd2); send(16'd3);
        idle(3);
        chk("blk1_issues", 64'(iss_q.size()), 64'd1);
        exp_blk = {16'd1, 16'd2, 16'd3};
        chk("blk1_din", 64'(iss_q[0]), 64'(exp_blk));
        chk("blk1_no_out_yet", 64'(out_q.size()), 64'd0);
        for (int i = 4; i <= 12; i++) send(16'(i));
        idle(10);
        chk("four_issues", 64'(iss_q.size()), 64'd4);
        chk("blk1_out_cnt", 64'(out_q.size()), 64'd3);
        chk("blk1_w1", out_q[0], 64'd1001);
        chk("blk1_w2", out_q[1], 64'd2002);
        chk("blk1_w3", out_q[2], 64'd3003);
        flush_pulse();
        idle(30);
        chk("drain1_done", 64'(fd_cnt), 64'd1);
        chk("drain1_issues", 64'(iss_q.size()), 64'd7);
        chk("drain1_bubbles", 64'(iss_q[4] | iss_q[5] | iss_q[6]), 64'd0);
        chk("drain1_words", 64'(out_q.size()), 64'd12);
        for (int i = 0; i < 12; i++)
            chk("drain1_word", out_q[i], model(16'(i + 1), (i % 3) + 1));

        // ---- output back-pressure with a continuous stream ----
        clear_logs();
        m_ready = 1'b0;
        for (int i = 0; i < 15; i++) send(16'(100 + i));
        s_valid = 1'b1;
        s_data  = 16'd115;
        rdy_hi  = 0;
        @(negedge clk);
        hold0 = m_data;
        repeat (20) begin
            @(negedge clk);
            if (s_ready) rdy_hi++;
        end
        @(posedge clk); #1;
        chk("stall_issues", 64'(iss_q.size()), 64'd4);
        chk("stall_ready_low", 64'(rdy_hi), 64'd0);
        chk("stall_m_valid", 64'(m_valid), 64'd1);
        chk("stall_m_data_first", hold0, 64'd100001);
        chk("stall_m_data_hold", m_data, 64'd100001);
        m_ready = 1'b1;
        send(16'd115); send(16'd116); send(16'd117);
        flush_pulse();
        idle(60);
        chk("stream_words", 64'(out_q.size()), 64'd18);
        for (int i = 0; i < 18; i++)
            chk("stream_word", out_q[i], model(16'(100 + i), (i % 3) + 1));
        chk("stream_flush_done", 64'(fd_cnt), 64'd1);

        // ---- partial block padded by flush ----
        clear_logs();
        send(16'd5); send(16'd6);
        flush_pulse();
        idle(30);
        chk("pad_issues", 64'(iss_q.size()), 64'd4);
        exp_blk = {16'd5, 16'd6, 16'd0};
        chk("pad_din", 64'(iss_q[0]), 64'(exp_blk));
        chk("pad_bubbles", 64'(iss_q[1] | iss_q[2] | iss_q[3]), 64'd0);
        chk("pad_flush_done", 64'(fd_cnt), 64'd1);
        chk("pad_words", 64'(out_q.size()), 64'd3);
        chk("pad_w1", out_q[0], 64'd5001);
        chk("pad_w2", out_q[1], 64'd6002);
        chk("pad_w3", out_q[2], 64'd3);

        // ---- flush together with the third sample ----
        clear_logs();
        send(16'd7); send(16'd8);
        s_valid = 1'b1;
        s_data  = 16'd9;
        flush   = 1'b1;
        @(negedge clk);
        chk("coflush_ready", 64'(s_ready), 64'd1);
        @(posedge clk); #1;
        s_valid = 1'b0;
        flush   = 1'b0;
        idle(30);
        chk("coflush_issues", 64'(iss_q.size()), 64'd4);
        exp_blk = {16'd7, 16'd8, 16'd9};
        chk("coflush_din", 64'(iss_q[0]), 64'(exp_blk));
        chk("coflush_flush_done", 64'(fd_cnt), 64'd1);
        chk("coflush_words", 64'(out_q.size()), 64'd3);
        chk("coflush_w3", out_q[2], 64'd9003);

        // ---- reset with blocks in flight ----
        clear_logs();
        m_ready = 1'b0;
        for (int i = 0; i < 12; i++) send(16'(200 + i));
        idle(3);
        chk("prerst_m_valid", 64'(m_valid), 64'd1);
        rst = 1'b0;
        #1;
        chk("midrst_m_valid", 64'(m_valid), 64'd0);
        chk("midrst_s_ready", 64'(s_ready), 64'd0);
        chk("midrst_m_data", m_data, 64'd0);
        idle(2);
        rst = 1'b1;
        idle(1);
        clear_logs();
        m_ready = 1'b1;
        for (int i = 0; i < 12; i++) send(16'(300 + i));
        idle(10);
        chk("postrst_words", 64'(out_q.size()), 64'd3);
        chk("postrst_w1", out_q[0], 64'd300001);
        chk("postrst_w2", out_q[1], 64'd301002);
        chk("postrst_w3", out_q[2], 64'd302003);
        flush_pulse();
        idle(40);
        chk("postrst_total", 64'(out_q.size()), 64'd12);
        chk("postrst_flush_done", 64'(fd_cnt), 64'd1);
`ifdef FIR3_SEQ_STATS_EN
        chk("blk_cnt", 64'(blk_cnt), 64'd4);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fir3_block_sequencer.md
FIR3_BLOCK_SEQUENCER -- requirements
Module: fir3_block_sequencer

Interface
REQ-001 Parameter DIN_W, default 16, input sample width.
REQ-002 Parameter DOUT_W, default 64, filter output width.
REQ-003 Parameter FILT_LAT, default 3, number of f_en advances from block issue to that block's result on f_dout1..3; range 1..8.
REQ-004 Parameter DEPTH, default 4, output buffer capacity in 3-sample blocks; power of two, range 2..16.
REQ-005 One clock; reset is asynchronous and active-low. Ports: clk and rst.
REQ-006 clk  input  1  sole clock, rising edge.
REQ-007 rst  input  1  asynchronous active-low reset.
REQ-008 s_data  input  DIN_W  serial input sample, signed.
REQ-009 s_valid / s_ready  input / output  1 each  input handshake.
REQ-010 flush  input  1  single-cycle drain request.
REQ-011 f_din1, f_din2, f_din3  output  DIN_W each  parallel block to the filter; f_din1 is the oldest sample.
REQ-012 f_en  output  1  filter pipeline advance strobe.
REQ-013 f_dout1, f_dout2, f_dout3  input  DOUT_W each  filter results.
REQ-014 m_data  output  DOUT_W  serial output sample.
REQ-015 m_valid / m_ready  output / input  1 each  output handshake.
REQ-016 flush_done  output  1  one-cycle pulse when the drain completes.

Function
REQ-017 A sample is accepted when s_valid and s_ready are both high; accepted samples fill phase slots 0, 1, 2 in order, mapped to f_din1, f_din2, f_din3.
REQ-018 A filled block is held in a block register; s_ready is low while the block register is full or the FSM is not in RUN.
REQ-019 FSM states: RUN, PAD, DRAIN. A flush pulse moves RUN to PAD if the phase is nonzero, else to DRAIN. PAD moves to DRAIN after the padded block issues. DRAIN moves to RUN when all tags are zero, pulsing flush_done in that cycle.
REQ-020 A reservation counter counts blocks issued but not yet fully serialized. A data issue is allowed only when the counter is below DEPTH.
REQ-021 Data issue: f_en is high for one cycle and f_din1..3 present the block register. Earliest issue is the cycle after the third sample is accepted. The tag shift register (FILT_LAT bits) shifts in 1.
REQ-022 PAD fills the unfilled slots with zero and issues the block as data, so all 3 results are emitted.
REQ-023 DRAIN issues bubble advances: f_en high, f_din1..3 = 0, tag shifts in 0. Bubbles ignore the reservation counter.
REQ-024 In the cycle after any f_en whose outgoing tag bit (bit FILT_LAT-1 before the shift) was 1, f_dout1..3 are written into the output FIFO as one entry.
REQ-025 The serializer emits the FIFO head as f_dout1, then f_dout2, then f_dout3 on m_data. Each word transfers on m_valid and m_ready. The reservation counter decrements when the third word transfers.
REQ-026 While m_valid is high and m_ready is low, m_data holds stable.
REQ-027 When an issue and a third-word transfer occur in the same cycle, the reservation counter is unchanged.
REQ-028 Flush in a non-RUN state is ignored. Flush arriving in the same cycle as the third sample is accepted: the sample completes the block, the phase becomes 0, and the FSM enters DRAIN.
REQ-029 The output FIFO never overflows, guaranteed by REQ-020. Popping an empty FIFO is impossible because m_valid = FIFO non-empty.

Reset
REQ-030 While rst is low: FSM = RUN, phase = 0, block register, tags, FIFO pointers and reservation counter = 0.
REQ-031 While rst is low: s_ready, f_en, m_valid, flush_done = 0; f_din1..3 = 0; m_data = 0.
REQ-032 s_ready rises in the first clk edge after rst goes high.
REQ-033 Reset mid-operation discards partial blocks, in-flight tags and buffered results without emitting them.

Configuration
REQ-034 With FIR3_SEQ_STATS_EN defined, output blk_cnt (16 bits) counts data issues, wraps at 65535 to 0, and resets to 0.
REQ-035 With FIR3_SEQ_STATS_EN undefined, port blk_cnt and its logic are absent; all other behaviour is identical.

Verification
REQ-036 Hold rst low, then release -> all outputs 0 during reset; s_ready = 1 one cycle after release.
REQ-037 Send samples 1, 2, 3 with m_ready = 1 -> f_en pulses once with f_din1/2/3 = 1/2/3. After 3 further data issues, m_data = f_dout1, f_dout2, f_dout3 of the first block, in order.
REQ-038 m_ready = 0 with a continuous input stream -> exactly 4 data issues, then f_en stays 0 and s_ready drops once the block register is full. Raising m_ready resumes the stream with no lost or duplicated words.
REQ-039 Send samples 5, 6, then flush -> one data issue with f_din = 5/6/0, then 3 bubble issues with f_din = 0. flush_done pulses once; 3 words are emitted.
REQ-040 Assert rst low mid-stream with 2 blocks in flight -> m_valid = 0 immediately. After release, the first output corresponds to the first post-reset block.
REQ-041 With FIR3_SEQ_STATS_EN defined, issue 65537 blocks -> blk_cnt = 1.
